// File: rtl/adc0809_emu_pkg.sv
// Shared types and constants for the ADC0809-style converter emulation.
package adc_pkg;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAR    = 2'd2
  } adc_state_e;

  // Channel assignments for the joystick inputs.
  localparam logic [1:0] CH_VERT  = 2'd0;
  localparam logic [1:0] CH_HORIZ = 2'd1;

  // Rest value for unused (spare) channels.
  localparam logic [7:0] CENTER   = 8'd127;

endpackage

// File: rtl/adc0809_emu_sar_step.sv
// One successive-approximation decision: try setting the current bit and
// keep it only if the held sample is still at or above the trial value.
module adc_sar_step (
  input  logic [7:0] sample_i,
  input  logic [7:0] approx_i,
  input  logic [2:0] bit_idx_i,
  output logic [7:0] approx_o
);

  logic [7:0] trial;

  // Trial value and unsigned compare against the held sample.
  always_comb begin
    trial    = approx_i | (8'h01 << bit_idx_i);
    approx_o = (sample_i >= trial) ? trial : approx_i;
  end

endmodule

// File: rtl/adc0809_emu.sv
// ADC0809-style 4-channel SAR converter emulation on the CPU bus.
// A falling edge on wr_n starts a conversion of channel a; eoc drops while
// converting and rises SETTLE_CYCLES + 8*STEP_CYCLES cycles after the start.
module adc0809_emu
  import adc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int STEP_CYCLES   = 72
) (
  input  logic        clk6m,
  input  logic        reset,
  input  logic [7:0]  ch0_in,
  input  logic [7:0]  ch1_in,
  input  logic [7:0]  ch2_in,
  input  logic [7:0]  ch3_in,
  input  logic [1:0]  a,
  input  logic        wr_n,
  input  logic        rd_n,
  output logic        eoc,
  output logic        eoc_pulse,
  output logic [15:0] data_out
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);

  adc_state_e    state_q, state_d;
  logic [1:0]    chan_q, chan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sample_q, sample_d;
  logic [7:0]    approx_q, approx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    result_q, result_d;
  logic          eoc_q, eoc_d;
  logic          eoc_pulse_q, eoc_pulse_d;
  logic [15:0]   data_q, data_d;
  logic          wr_prev_q;

  logic          start;
  logic [7:0]    ch_mux;
  logic [7:0]    approx_next;

  assign start = wr_prev_q & ~wr_n;

  // Analog multiplexer driven by the channel latched at start.
  always_comb begin
    case (chan_q)
      CH_VERT:  ch_mux = ch0_in;
      CH_HORIZ: ch_mux = ch1_in;
      2'd2:     ch_mux = ch2_in;
      default:  ch_mux = ch3_in;
    endcase
  end

  adc_sar_step u_sar_step (
    .sample_i  (sample_q),
    .approx_i  (approx_q),
    .bit_idx_i (bit_idx_q),
    .approx_o  (approx_next)
  );

  // Next-state logic: settle, bitwise SAR, commit; a start always wins last.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    approx_d    = approx_q;
    bit_idx_d   = bit_idx_q;
    result_d    = result_q;
    eoc_d       = eoc_q;
    eoc_pulse_d = 1'b0;
    data_d      = rd_n ? data_q : {8'h00, result_q};

    case (state_q)
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          sample_d  = ch_mux;
          bit_idx_d = 3'd7;
          cnt_d     = '0;
          state_d   = SAR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAR: begin
        if (cnt_q == STEP_LAST) begin
          approx_d = approx_next;
          cnt_d    = '0;
          if (bit_idx_q == 3'd0) begin
            result_d    = approx_next;
            eoc_d       = 1'b1;
            eoc_pulse_d = 1'b1;
            state_d     = IDLE;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    // A start aborts or follows any in-flight work; a same-cycle commit
    // above still lands in result/eoc_pulse.
    if (start) begin
      chan_d   = a;
      eoc_d    = 1'b0;
      cnt_d    = '0;
      approx_d = '0;
      state_d  = SETTLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk6m) begin
    if (reset) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      approx_q    <= '0;
      bit_idx_q   <= '0;
      result_q    <= '0;
      eoc_q       <= 1'b1;
      eoc_pulse_q <= 1'b0;
      data_q      <= '0;
      wr_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      approx_q    <= approx_d;
      bit_idx_q   <= bit_idx_d;
      result_q    <= result_d;
      eoc_q       <= eoc_d;
      eoc_pulse_q <= eoc_pulse_d;
      data_q      <= data_d;
      wr_prev_q   <= wr_n;
    end
  end

  assign eoc       = eoc_q;
  assign eoc_pulse = eoc_pulse_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_adc0809_emu.sv
// Directed self-checking bench for adc0809_emu (SETTLE=2, STEP=4, latency 34).
module tb_adc0809_emu;
  import adc_pkg::*;

  localparam int LAT = 34;

  logic        clk6m = 1'b0;
  logic        reset;
  logic [7:0]  ch0_in, ch1_in, ch2_in, ch3_in;
  logic [1:0]  a;
  logic        wr_n, rd_n;
  logic        eoc, eoc_pulse;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;

  adc0809_emu #(
    .SETTLE_CYCLES (2),
    .STEP_CYCLES   (4)
  ) dut (
    .clk6m     (clk6m),
    .reset     (reset),
    .ch0_in    (ch0_in),
    .ch1_in    (ch1_in),
    .ch2_in    (ch2_in),
    .ch3_in    (ch3_in),
    .a         (a),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .eoc       (eoc),
    .eoc_pulse (eoc_pulse),
    .data_out  (data_out)
  );

  always #5 clk6m = ~clk6m;

  typedef struct {
    logic [1:0]  a;
    logic [7:0]  c0, c1, c2, c3;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue a one-cycle wr_n low; returns at the first negedge after the start edge.
  task automatic do_start(input logic [1:0] aa);
    a    = aa;
    wr_n = 1'b0;
    @(negedge clk6m);
    wr_n = 1'b1;
  endtask

  // One-cycle read; returns with data_out reflecting the read.
  task automatic do_read(output logic [15:0] d);
    rd_n = 1'b0;
    @(negedge clk6m);
    rd_n = 1'b1;
    d = data_out;
  endtask

  // Count negedges with eoc low (starting from 'already'), bounded.
  task automatic wait_eoc(input int already, output int lowc, output int pulses);
    lowc   = already;
    pulses = 0;
    while (eoc == 1'b0 && lowc < 300) begin
      if (eoc_pulse) pulses++;
      lowc++;
      @(negedge clk6m);
    end
  endtask

  // Check eoc_pulse high now and low on the following cycle.
  task automatic chk_pulse(input string name);
    chk({name, "_pulse_hi"}, {31'd0, eoc_pulse}, 32'd1);
    @(negedge clk6m);
    chk({name, "_pulse_lo"}, {31'd0, eoc_pulse}, 32'd0);
  endtask

  initial begin
    int          lowc, pulses, errs;
    logic [15:0] d;
    logic [15:0] last_res;

    vecs[0] = '{a: 2'd1, c0: 8'h00, c1: 8'hA5, c2: CENTER, c3: CENTER, exp: 16'h00A5};
    vecs[1] = '{a: 2'd0, c0: 8'hFF, c1: 8'hA5, c2: CENTER, c3: CENTER, exp: 16'h00FF};
    vecs[2] = '{a: 2'd0, c0: 8'h00, c1: 8'hFF, c2: CENTER, c3: CENTER, exp: 16'h0000};
    vecs[3] = '{a: 2'd2, c0: 8'h11, c1: 8'h22, c2: 8'h5A,  c3: CENTER, exp: 16'h005A};
    vecs[4] = '{a: 2'd3, c0: 8'h11, c1: 8'h22, c2: 8'h5A,  c3: 8'h81,  exp: 16'h0081};

    reset = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a = 2'd0;
    ch0_in = 8'h00; ch1_in = 8'h00; ch2_in = CENTER; ch3_in = CENTER;
    repeat (3) @(negedge clk6m);
    reset = 1'b0;
    @(negedge clk6m);

    // Reset state
    chk("rst_eoc", {31'd0, eoc}, 32'd1);
    chk("rst_pulse", {31'd0, eoc_pulse}, 32'd0);
    do_read(d);
    chk("rst_read", {16'd0, d}, 32'h0000);
    $display("reset read data_out=%04h eoc=%0b", d, eoc);

    // Table-driven conversions
    for (int i = 0; i < 5; i++) begin
      ch0_in = vecs[i].c0; ch1_in = vecs[i].c1;
      ch2_in = vecs[i].c2; ch3_in = vecs[i].c3;
      do_start(vecs[i].a);
      wait_eoc(0, lowc, pulses);
      chk("vec_latency", lowc, LAT);
      chk("vec_early_pulse", pulses, 0);
      chk_pulse("vec");
      do_read(d);
      chk("vec_result", {16'd0, d}, {16'd0, vecs[i].exp});
      $display("vec %0d a=%0d lat=%0d data_out=%04h", i, vecs[i].a, lowc, d);
    end
    last_res = 16'h0081;

    // Input change after sampling, plus read mid-conversion
    ch0_in = 8'h40;
    do_start(2'd0);
    repeat (4) @(negedge clk6m);
    ch0_in = 8'hC0;
    do_read(d);
    chk("mid_read", {16'd0, d}, {16'd0, last_res});
    wait_eoc(5, lowc, pulses);
    chk("hold_latency", lowc, LAT);
    chk_pulse("hold");
    do_read(d);
    chk("hold_result", {16'd0, d}, 32'h0040);
    $display("sample-hold conv data_out=%04h mid=%04h", d, last_res);
    last_res = 16'h0040;

    // Restart after 10 cycles on another channel
    ch0_in = 8'h11; ch1_in = 8'h33;
    do_start(2'd0);
    repeat (10) @(negedge clk6m);
    chk("restart_eoc_low", {31'd0, eoc}, 32'd0);
    do_start(2'd1);
    wait_eoc(0, lowc, pulses);
    chk("restart_latency", lowc, LAT);
    chk("restart_no_pulse", pulses, 0);
    chk_pulse("restart");
    do_read(d);
    chk("restart_result", {16'd0, d}, 32'h0033);
    $display("restart conv lat=%0d data_out=%04h", lowc, d);

    // Start coinciding with the final SAR step
    ch0_in = 8'h3C; ch1_in = 8'hC3;
    do_start(2'd0);
    repeat (33) @(negedge clk6m);
    ch1_in = 8'hC3;
    a = 2'd1; wr_n = 1'b0;
    @(negedge clk6m);
    wr_n = 1'b1;
    chk("coinc_pulse", {31'd0, eoc_pulse}, 32'd1);
    chk("coinc_eoc", {31'd0, eoc}, 32'd0);
    do_read(d);
    chk("coinc_first", {16'd0, d}, 32'h003C);
    wait_eoc(1, lowc, pulses);
    chk("coinc_latency", lowc, LAT);
    chk_pulse("coinc");
    do_read(d);
    chk("coinc_second", {16'd0, d}, 32'h00C3);
    $display("coincident start first=003c second=%04h lat=%0d", d, lowc);

    // wr_n held low, with a read in the start cycle
    ch1_in = 8'h96;
    a = 2'd1; wr_n = 1'b0; rd_n = 1'b0;
    @(negedge clk6m);
    rd_n = 1'b1;
    chk("startread_data", {16'd0, data_out}, 32'h00C3);
    wait_eoc(0, lowc, pulses);
    chk("held_latency", lowc, LAT);
    repeat (6) @(negedge clk6m);
    chk("held_no_retrig", {31'd0, eoc}, 32'd1);
    wr_n = 1'b1;
    @(negedge clk6m);
    do_read(d);
    chk("held_result", {16'd0, d}, 32'h0096);
    $display("held wr_n conv lat=%0d data_out=%04h", lowc, d);

    // Reset mid-conversion
    ch1_in = 8'h77;
    do_start(2'd1);
    repeat (19) @(negedge clk6m);
    reset = 1'b1;
    @(negedge clk6m);
    reset = 1'b0;
    chk("abort_eoc", {31'd0, eoc}, 32'd1);
    chk("abort_data", {16'd0, data_out}, 32'h0000);
    chk("abort_pulse", {31'd0, eoc_pulse}, 32'd0);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk6m);
      if (eoc_pulse || !eoc) errs++;
    end
    chk("abort_quiet", errs, 0);
    do_read(d);
    chk("abort_result", {16'd0, d}, 32'h0000);
    $display("reset abort data_out=%04h quiet_errs=%0d", d, errs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
